// File: rtl/riscv_mpsoc_pkg.sv
// rtl/riscv_mpsoc_pkg.sv - shared LSU access-size and FSM state encodings
package riscv_mpsoc_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'd0,
        SIZE_HALF  = 2'd1,
        SIZE_WORD  = 2'd2,
        SIZE_DWORD = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'd0,
        LSU_BUSY  = 2'd1,
        LSU_DRAIN = 2'd2
    } lsu_state_e;

    // Byte-enable pattern for an access of the given size at lane 0.
    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        case (lsu_size_e'(sz))
            SIZE_BYTE:  size_mask = 8'h01;
            SIZE_HALF:  size_mask = 8'h03;
            SIZE_WORD:  size_mask = 8'h0F;
            default:    size_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// rtl/riscv_lsu_align.sv - byte-lane steering for stores and load extraction/extension
module riscv_lsu_align
    import riscv_mpsoc_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [1:0]        wr_size_i,
    input  logic [2:0]        wr_off_i,
    input  logic [XLEN-1:0]   wr_data_i,
    output logic [XLEN/8-1:0] wr_be_o,
    output logic [XLEN-1:0]   wr_data_o,
    input  logic [2:0]        rd_size_i,
    input  logic [2:0]        rd_off_i,
    input  logic [XLEN-1:0]   rd_data_i,
    output logic [XLEN-1:0]   rd_data_o
);

    localparam int BEW = XLEN / 8;

    logic [XLEN-1:0] rd_shift;

    always_comb begin
        wr_be_o   = BEW'(size_mask(wr_size_i)) << wr_off_i;
        wr_data_o = wr_data_i << {wr_off_i, 3'b000};
        rd_shift  = rd_data_i >> {rd_off_i, 3'b000};
        // rd_size_i[2] selects zero-extension instead of sign-extension
        case (lsu_size_e'(rd_size_i[1:0]))
            SIZE_BYTE: rd_data_o = rd_size_i[2] ? XLEN'(rd_shift[7:0])
                                                : XLEN'($signed(rd_shift[7:0]));
            SIZE_HALF: rd_data_o = rd_size_i[2] ? XLEN'(rd_shift[15:0])
                                                : XLEN'($signed(rd_shift[15:0]));
            SIZE_WORD: rd_data_o = rd_size_i[2] ? XLEN'(rd_shift[31:0])
                                                : XLEN'($signed(rd_shift[31:0]));
            default:   rd_data_o = rd_shift;
        endcase
    end

endmodule

// File: rtl/riscv_lsu_ctrl.sv
// rtl/riscv_lsu_ctrl.sv - single-outstanding load/store unit bus controller
module riscv_lsu_ctrl
    import riscv_mpsoc_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic              rstn,
    input  logic              clk,
    input  logic              ex_req,
    input  logic              ex_bubble,
    input  logic              ex_we,
    input  logic [2:0]        ex_size,
    input  logic [XLEN-1:0]   ex_adr,
    input  logic [XLEN-1:0]   ex_d,
    input  logic              flush,
    output logic              lsu_stall,
    output logic              lsu_valid,
    output logic [XLEN-1:0]   lsu_q,
    output logic              misaligned_ld,
    output logic              misaligned_st,
    output logic              access_fault,
    output logic              dmem_req,
    output logic [XLEN-1:0]   dmem_adr,
    output logic              dmem_we,
    output logic [XLEN/8-1:0] dmem_be,
    output logic [XLEN-1:0]   dmem_d,
    input  logic              dmem_ack,
    input  logic              dmem_err,
    input  logic [XLEN-1:0]   dmem_q
);

    localparam int OFFW = (XLEN == 64) ? 3 : 2;

    lsu_state_e        state_q;
    logic              dmem_req_q, dmem_we_q;
    logic [XLEN-1:0]   dmem_adr_q, dmem_d_q;
    logic [XLEN/8-1:0] dmem_be_q;
    logic [2:0]        size_q, off_q;
    logic              lsu_valid_q, access_fault_q, mis_ld_q, mis_st_q;
    logic [XLEN-1:0]   lsu_q_q;

    logic              aligned, cand, accept, misalign;
    logic [2:0]        ex_off;
    logic [XLEN/8-1:0] be_d;
    logic [XLEN-1:0]   wdata_d, rdata_ext;

    assign ex_off = (XLEN == 64) ? ex_adr[2:0] : {1'b0, ex_adr[1:0]};

    always_comb begin
        aligned = 1'b0;
        case (lsu_size_e'(ex_size[1:0]))
            SIZE_BYTE:  aligned = 1'b1;
            SIZE_HALF:  aligned = ~ex_adr[0];
            SIZE_WORD:  aligned = (ex_adr[1:0] == 2'b00);
            SIZE_DWORD: aligned = (XLEN == 64) && (ex_adr[2:0] == 3'b000);
            default:    aligned = 1'b0;
        endcase
    end

    assign cand      = (state_q == LSU_IDLE) && ex_req && !ex_bubble && !flush;
    assign accept    = cand && aligned;
    assign misalign  = cand && !aligned;
    assign lsu_stall = accept || (state_q != LSU_IDLE);

    riscv_lsu_align #(.XLEN(XLEN)) u_align (
        .wr_size_i (ex_size[1:0]),
        .wr_off_i  (ex_off),
        .wr_data_i (ex_d),
        .wr_be_o   (be_d),
        .wr_data_o (wdata_d),
        .rd_size_i (size_q),
        .rd_off_i  (off_q),
        .rd_data_i (dmem_q),
        .rd_data_o (rdata_ext)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= LSU_IDLE;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_adr_q     <= '0;
            dmem_be_q      <= '0;
            dmem_d_q       <= '0;
            size_q         <= '0;
            off_q          <= '0;
            lsu_valid_q    <= 1'b0;
            access_fault_q <= 1'b0;
            mis_ld_q       <= 1'b0;
            mis_st_q       <= 1'b0;
            lsu_q_q        <= '0;
        end else begin
            lsu_valid_q    <= 1'b0;
            access_fault_q <= 1'b0;
            mis_ld_q       <= misalign && !ex_we;
            mis_st_q       <= misalign && ex_we;
            case (state_q)
                LSU_IDLE: begin
                    if (accept) begin
                        state_q    <= LSU_BUSY;
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= ex_we;
                        dmem_adr_q <= {ex_adr[XLEN-1:OFFW], {OFFW{1'b0}}};
                        dmem_be_q  <= be_d;
                        dmem_d_q   <= wdata_d;
                        size_q     <= ex_size;
                        off_q      <= ex_off;
                    end
                end
                LSU_BUSY: begin
                    if (dmem_ack) begin
                        state_q    <= LSU_IDLE;
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        dmem_be_q  <= '0;
                        // A flush coinciding with ack kills the result like a drain would
                        if (!flush) begin
                            if (dmem_err) begin
                                access_fault_q <= 1'b1;
                            end else begin
                                lsu_valid_q <= 1'b1;
                                lsu_q_q     <= dmem_we_q ? '0 : rdata_ext;
                            end
                        end
                    end else if (flush) begin
                        state_q <= LSU_DRAIN;
                    end
                end
                LSU_DRAIN: begin
                    if (dmem_ack) begin
                        state_q    <= LSU_IDLE;
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        dmem_be_q  <= '0;
                    end
                end
                default: state_q <= LSU_IDLE;
            endcase
        end
    end

    assign dmem_req      = dmem_req_q;
    assign dmem_we       = dmem_we_q;
    assign dmem_adr      = dmem_adr_q;
    assign dmem_be       = dmem_be_q;
    assign dmem_d        = dmem_d_q;
    assign lsu_valid     = lsu_valid_q;
    assign lsu_q         = lsu_q_q;
    assign access_fault  = access_fault_q;
    assign misaligned_ld = mis_ld_q;
    assign misaligned_st = mis_st_q;

endmodule

// File: tb/tb_riscv_lsu_ctrl.sv
// tb/tb_riscv_lsu_ctrl.sv - scoreboard bench for riscv_lsu_ctrl with a delayed-ack bus responder
module tb_riscv_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ex_req = 1'b0, ex_bubble = 1'b0, ex_we = 1'b0, flush = 1'b0;
    logic [2:0]  ex_size = '0;
    logic [63:0] ex_adr = '0, ex_d = '0;
    logic        lsu_stall, lsu_valid, misaligned_ld, misaligned_st, access_fault;
    logic [63:0] lsu_q, dmem_adr, dmem_d;
    logic        dmem_req, dmem_we;
    logic [7:0]  dmem_be;
    logic        dmem_ack = 1'b0, dmem_err = 1'b0;
    logic [63:0] dmem_q = '0;

    riscv_lsu_ctrl #(.XLEN(64)) dut (
        .rstn(rstn), .clk(clk), .ex_req(ex_req), .ex_bubble(ex_bubble), .ex_we(ex_we),
        .ex_size(ex_size), .ex_adr(ex_adr), .ex_d(ex_d), .flush(flush),
        .lsu_stall(lsu_stall), .lsu_valid(lsu_valid), .lsu_q(lsu_q),
        .misaligned_ld(misaligned_ld), .misaligned_st(misaligned_st), .access_fault(access_fault),
        .dmem_req(dmem_req), .dmem_adr(dmem_adr), .dmem_we(dmem_we), .dmem_be(dmem_be),
        .dmem_d(dmem_d), .dmem_ack(dmem_ack), .dmem_err(dmem_err), .dmem_q(dmem_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          fault;
        logic [63:0] q;
        int          icyc;
        int          lat;
    } exp_t;

    typedef struct {
        logic [2:0]  size;
        logic [63:0] adr;
        logic [63:0] rsp;
        logic [7:0]  be;
        logic [63:0] exp;
        int          dly;
    } ld_t;

    exp_t        sb[$];
    exp_t        mon_e;
    ld_t         tbl[7];
    int          cyc = 0;
    int          n_chk = 0, n_pass = 0;
    int          ack_delay = 0, wait_cnt = 0;
    logic        rsp_err = 1'b0;
    logic [63:0] rsp_q = '0;

    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    endtask

    // Bus slave: acks ack_delay cycles after seeing a request, for one cycle
    always @(negedge clk) begin
        if (dmem_ack) begin
            dmem_ack = 1'b0;
            dmem_err = 1'b0;
        end else if (dmem_req) begin
            if (wait_cnt >= ack_delay) begin
                dmem_ack = 1'b1;
                dmem_err = rsp_err;
                dmem_q   = rsp_q;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (rstn && (lsu_valid || access_fault)) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_done", {62'd0, lsu_valid, access_fault}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("fault", access_fault, mon_e.fault);
                check_eq("valid", lsu_valid, !mon_e.fault);
                if (!mon_e.fault) check_eq("lsu_q", lsu_q, mon_e.q);
                check_eq("latency", cyc - mon_e.icyc, mon_e.lat);
            end
        end
    end

    // Called just after a rising edge; kind 0=no completion, 1=valid, 2=fault
    task automatic issue(input logic we, input logic [2:0] size, input logic [63:0] adr,
                         input logic [63:0] d, input int kind, input logic [63:0] exp_q,
                         input logic exp_stall);
        exp_t e;
        ex_req = 1'b1; ex_we = we; ex_size = size; ex_adr = adr; ex_d = d;
        if (kind != 0) begin
            e.fault = (kind == 2);
            e.q     = exp_q;
            e.icyc  = cyc;
            e.lat   = 2 + ack_delay;
            sb.push_back(e);
        end
        @(negedge clk);
        check_eq("stall_ex", lsu_stall, exp_stall);
        @(posedge clk); #1;
        ex_req = 1'b0; ex_we = 1'b0; ex_size = '0; ex_adr = '0; ex_d = '0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!lsu_stall && !dmem_req) return;
        end
        check_eq("idle_timeout", 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{3'b010, 64'h8000_0004, 64'h8000_0000_0000_0000, 8'hF0, 64'hFFFF_FFFF_8000_0000, 0};
        tbl[1] = '{3'b100, 64'h0000_0105, 64'h0000_9A00_0000_0000, 8'h20, 64'h0000_0000_0000_009A, 1};
        tbl[2] = '{3'b000, 64'h0000_0105, 64'h0000_9A00_0000_0000, 8'h20, 64'hFFFF_FFFF_FFFF_FF9A, 0};
        tbl[3] = '{3'b001, 64'h0000_0206, 64'h8123_0000_0000_0000, 8'hC0, 64'hFFFF_FFFF_FFFF_8123, 2};
        tbl[4] = '{3'b110, 64'h8000_0004, 64'h8000_0000_0000_0000, 8'hF0, 64'h0000_0000_8000_0000, 0};
        tbl[5] = '{3'b011, 64'h0000_1008, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF, 1};
        tbl[6] = '{3'b101, 64'h0000_3002, 64'h0000_0000_F00D_0000, 8'h0C, 64'h0000_0000_0000_F00D, 0};

        repeat (2) @(negedge clk);
        check_eq("rst_req", dmem_req, 0);
        check_eq("rst_stall", lsu_stall, 0);
        check_eq("rst_valid", lsu_valid, 0);
        check_eq("rst_lsu_q", lsu_q, 0);
        check_eq("rst_be", dmem_be, 0);
        check_eq("rst_adr", dmem_adr, 0);
        check_eq("rst_d", dmem_d, 0);
        check_eq("rst_pulses", {misaligned_ld, misaligned_st, access_fault}, 0);
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            ack_delay = tbl[i].dly; rsp_q = tbl[i].rsp; rsp_err = 1'b0;
            issue(1'b0, tbl[i].size, tbl[i].adr, 64'd0, 1, tbl[i].exp, 1'b1);
            @(negedge clk);
            check_eq("ld_be", dmem_be, tbl[i].be);
            check_eq("ld_adr", dmem_adr, tbl[i].adr & ~64'h7);
            check_eq("ld_req_we", {dmem_req, dmem_we}, 2'b10);
            wait_idle();
            @(posedge clk); #1;
        end

        ack_delay = 2;
        issue(1'b1, 3'b000, 64'h1000_0003, 64'hAB, 1, 64'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("stb_stall", lsu_stall, 1);
            check_eq("stb_req_we", {dmem_req, dmem_we}, 2'b11);
            check_eq("stb_be", dmem_be, 8'h08);
            check_eq("stb_d", dmem_d, 64'h0000_0000_AB00_0000);
        end
        @(negedge clk);
        check_eq("stb_stall_rel", lsu_stall, 0);
        @(posedge clk); #1;

        ack_delay = 0;
        issue(1'b1, 3'b001, 64'h0000_2002, 64'h1234, 1, 64'd0, 1'b1);
        @(negedge clk);
        check_eq("sth_be", dmem_be, 8'h0C);
        check_eq("sth_d", dmem_d, 64'h0000_0000_1234_0000);
        wait_idle();
        @(posedge clk); #1;

        issue(1'b0, 3'b001, 64'h0000_5001, 64'd0, 0, 64'd0, 1'b0);
        @(negedge clk);
        check_eq("mis_ldh", {misaligned_ld, misaligned_st, dmem_req}, 3'b100);
        @(negedge clk);
        check_eq("mis_ldh_once", {misaligned_ld, dmem_req}, 2'b00);
        @(posedge clk); #1;
        issue(1'b0, 3'b010, 64'h0000_6002, 64'd0, 0, 64'd0, 1'b0);
        @(negedge clk);
        check_eq("mis_ldw", {misaligned_ld, misaligned_st, dmem_req}, 3'b100);
        @(posedge clk); #1;
        issue(1'b1, 3'b011, 64'h0000_4004, 64'd0, 0, 64'd0, 1'b0);
        @(negedge clk);
        check_eq("mis_std", {misaligned_ld, misaligned_st, dmem_req}, 3'b010);
        @(negedge clk);
        check_eq("mis_std_once", misaligned_st, 0);
        @(posedge clk); #1;

        flush = 1'b1;
        issue(1'b0, 3'b010, 64'h0000_7000, 64'd0, 0, 64'd0, 1'b0);
        flush = 1'b0;
        @(negedge clk);
        check_eq("flush_idle_req", dmem_req, 0);
        @(posedge clk); #1 flush = 1'b1;
        issue(1'b0, 3'b001, 64'h0000_7001, 64'd0, 0, 64'd0, 1'b0);
        flush = 1'b0;
        @(negedge clk);
        check_eq("flush_idle_mis", misaligned_ld, 0);
        @(posedge clk); #1 ex_bubble = 1'b1;
        issue(1'b0, 3'b010, 64'h0000_7000, 64'd0, 0, 64'd0, 1'b0);
        ex_bubble = 1'b0;
        @(negedge clk);
        check_eq("bubble_req", dmem_req, 0);
        @(posedge clk); #1;

        ack_delay = 3; rsp_q = 64'hDEAD_BEEF_DEAD_BEEF;
        issue(1'b0, 3'b010, 64'h0000_9000, 64'd0, 0, 64'd0, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        check_eq("drain_req0", {dmem_req, lsu_stall}, 2'b11);
        @(posedge clk); #1 flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("drain_req", {dmem_req, lsu_stall}, 2'b11);
            check_eq("drain_adr", dmem_adr, 64'h0000_9000);
        end
        @(negedge clk);
        check_eq("drain_release", {dmem_req, lsu_stall}, 2'b00);
        @(posedge clk); #1;

        ack_delay = 1; rsp_err = 1'b1;
        issue(1'b0, 3'b010, 64'h0000_A000, 64'd0, 2, 64'd0, 1'b1);
        wait_idle();
        rsp_err = 1'b0;
        @(posedge clk); #1;
        ack_delay = 0; rsp_q = 64'h0000_0000_0000_0077;
        issue(1'b0, 3'b100, 64'h0000_A000, 64'd0, 1, 64'h77, 1'b1);
        wait_idle();
        @(posedge clk); #1;

        ack_delay = 5;
        issue(1'b0, 3'b010, 64'h0000_B000, 64'd0, 0, 64'd0, 1'b1);
        @(negedge clk);
        check_eq("rstmid_req", dmem_req, 1);
        @(posedge clk); #1 rstn = 1'b0;
        #1;
        check_eq("rstmid_bus", {dmem_req, dmem_we, lsu_stall, lsu_valid, access_fault}, 0);
        check_eq("rstmid_be", dmem_be, 0);
        check_eq("rstmid_adr", dmem_adr, 0);
        @(posedge clk); #1 rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("rstmid_quiet", {dmem_req, lsu_stall}, 2'b00);
        end

        repeat (3) @(negedge clk);
        check_eq("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
